// File: rtl/config_pkg.sv
// Core configuration and the decoded CSR uop payload shared by issue, serializer and execute_csr.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
   } cfg_t;

   localparam cfg_t EmptyCfg = '{XLEN: 32};

   typedef enum logic [2:0] {
      CSR_NONE = 3'd0,
      CSR_RW   = 3'd1,
      CSR_RS   = 3'd2,
      CSR_RC   = 3'd3,
      CSR_RWI  = 3'd5,
      CSR_RSI  = 3'd6,
      CSR_RCI  = 3'd7
   } csr_op_e;

   typedef struct packed {
      logic        is_csr;
      csr_op_e     csr_op;
      logic [11:0] csr_addr;
      logic [4:0]  imm;
   } uop_t;

   localparam logic [11:0] CSR_ADDR_SATP    = 12'h180;
   localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;

endpackage

// File: rtl/csr_serializer.sv
// Holds one CSR uop until it is the ROB head with the LSU drained, fires execute_csr once,
// then returns the registered result to writeback; fences after SATP/MSTATUS accesses.
module csr_serializer
   import config_pkg::*;
#(
   parameter cfg_t        Cfg   = EmptyCfg,
   parameter int unsigned TAG_W = 6,
   parameter int unsigned XLEN  = Cfg.XLEN
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  uop_t             req_uop_i,
   input  logic [XLEN-1:0]  req_rs1_data_i,
   input  logic [TAG_W-1:0] req_rob_tag_i,
   input  logic             rob_head_valid_i,
   input  logic [TAG_W-1:0] rob_head_tag_i,
   input  logic             lsu_idle_i,
   input  logic             flush_i,
   output logic             csr_valid_o,
   output uop_t             csr_uop_o,
   output logic [XLEN-1:0]  csr_rs1_data_o,
   output logic [TAG_W-1:0] csr_rob_tag_o,
   input  logic [XLEN-1:0]  csr_result_i,
   input  logic             csr_exception_i,
   input  logic [4:0]       csr_ecause_i,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output logic [TAG_W-1:0] wb_rob_tag_o,
   output logic [XLEN-1:0]  wb_result_o,
   output logic             wb_exception_o,
   output logic [4:0]       wb_ecause_o,
   output logic             fence_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_HEAD = 2'd1,
      S_EXEC      = 2'd2,
      S_WB        = 2'd3
   } state_e;

   state_e           r_state;
   state_e           w_state_nxt;
   uop_t             r_uop;
   logic [XLEN-1:0]  r_rs1;
   logic [TAG_W-1:0] r_tag;
   logic [XLEN-1:0]  r_wb_result;
   logic             r_wb_exc;
   logic [4:0]       r_wb_cause;
   logic             r_fence;

   logic             w_accept;
   logic             w_exec;
   logic             w_wb_hs;
   logic             w_head_ok;
   logic             w_fence_addr;

   // Issue condition: the held uop is the oldest instruction and no memory op can race it.
   assign w_head_ok    = rob_head_valid_i && (rob_head_tag_i == r_tag) && lsu_idle_i;
   assign w_fence_addr = (r_uop.csr_addr == CSR_ADDR_SATP) ||
                         (r_uop.csr_addr == CSR_ADDR_MSTATUS);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready_o = 1'b0;
      csr_valid_o = 1'b0;
      wb_valid_o  = 1'b0;
      w_accept    = 1'b0;
      w_exec      = 1'b0;
      w_wb_hs     = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready_o = !flush_i && !rst_i;
            if (req_valid_i && !flush_i && !rst_i) begin
               w_accept    = 1'b1;
               w_state_nxt = S_WAIT_HEAD;
            end
         end
         S_WAIT_HEAD: begin
            if (flush_i)        w_state_nxt = S_IDLE;
            else if (w_head_ok) w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            // A flush in this cycle must leave the CSR file untouched.
            csr_valid_o = !flush_i && !rst_i;
            w_exec      = !flush_i && !rst_i;
            w_state_nxt = flush_i ? S_IDLE : S_WB;
         end
         S_WB: begin
            wb_valid_o = !rst_i;
            if (flush_i) begin
               w_state_nxt = S_IDLE;
            end else if (wb_ready_i) begin
               w_wb_hs     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_uop       <= '0;
         r_rs1       <= '0;
         r_tag       <= '0;
         r_wb_result <= '0;
         r_wb_exc    <= 1'b0;
         r_wb_cause  <= 5'd0;
         r_fence     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_uop <= req_uop_i;
            r_rs1 <= req_rs1_data_i;
            r_tag <= req_rob_tag_i;
         end
         if (w_exec) begin
            r_wb_result <= csr_result_i;
            r_wb_exc    <= csr_exception_i;
            r_wb_cause  <= csr_exception_i ? csr_ecause_i : 5'd0;
         end
         r_fence <= w_wb_hs && !r_wb_exc && w_fence_addr;
      end
   end

   assign csr_uop_o      = r_uop;
   assign csr_rs1_data_o = r_rs1;
   assign csr_rob_tag_o  = r_tag;
   assign wb_rob_tag_o   = r_tag;
   assign wb_result_o    = r_wb_result;
   assign wb_exception_o = r_wb_exc;
   assign wb_ecause_o    = r_wb_cause;
   assign fence_o        = r_fence;
   assign busy_o         = (r_state != S_IDLE) && !rst_i;

endmodule

// File: tb/tb_csr_serializer.sv
// Bench for csr_serializer: execute_csr model, vector table, corner sequences, random transactions.
module tb_csr_serializer;
   import config_pkg::*;

   logic        clk_i;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   uop_t        req_uop_i;
   logic [31:0] req_rs1_data_i;
   logic [5:0]  req_rob_tag_i;
   logic        rob_head_valid_i;
   logic [5:0]  rob_head_tag_i;
   logic        lsu_idle_i;
   logic        flush_i;
   logic        csr_valid_o;
   uop_t        csr_uop_o;
   logic [31:0] csr_rs1_data_o;
   logic [5:0]  csr_rob_tag_o;
   logic [31:0] csr_result_i;
   logic        csr_exception_i;
   logic [4:0]  csr_ecause_i;
   logic        wb_valid_o;
   logic        wb_ready_i;
   logic [5:0]  wb_rob_tag_o;
   logic [31:0] wb_result_o;
   logic        wb_exception_o;
   logic [4:0]  wb_ecause_o;
   logic        fence_o;
   logic        busy_o;

   csr_serializer dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_uop_i(req_uop_i),
      .req_rs1_data_i(req_rs1_data_i), .req_rob_tag_i(req_rob_tag_i),
      .rob_head_valid_i(rob_head_valid_i), .rob_head_tag_i(rob_head_tag_i),
      .lsu_idle_i(lsu_idle_i), .flush_i(flush_i),
      .csr_valid_o(csr_valid_o), .csr_uop_o(csr_uop_o), .csr_rs1_data_o(csr_rs1_data_o),
      .csr_rob_tag_o(csr_rob_tag_o), .csr_result_i(csr_result_i),
      .csr_exception_i(csr_exception_i), .csr_ecause_i(csr_ecause_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rob_tag_o(wb_rob_tag_o),
      .wb_result_o(wb_result_o), .wb_exception_o(wb_exception_o), .wb_ecause_o(wb_ecause_o),
      .fence_o(fence_o), .busy_o(busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   // Implemented CSRs: satp, mstatus, mtvec, mscratch, mepc; anything else is illegal (cause 2).
   function automatic int csr_idx(input logic [11:0] a);
      case (a)
         12'h180: return 0;
         12'h300: return 1;
         12'h305: return 2;
         12'h340: return 3;
         12'h341: return 4;
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] csr_new(input uop_t u, input logic [31:0] rs1,
                                           input logic [31:0] old);
      logic [31:0] src;
      src = (u.csr_op inside {CSR_RWI, CSR_RSI, CSR_RCI}) ? {27'd0, u.imm} : rs1;
      case (u.csr_op)
         CSR_RW, CSR_RWI: return src;
         CSR_RS, CSR_RSI: return old | src;
         CSR_RC, CSR_RCI: return old & ~src;
         default:         return old;
      endcase
   endfunction

   // execute_csr stand-in: combinational read, write on the edge where csr_valid_o is high.
   logic [31:0] env_csr [5];
   logic [31:0] ref_csr [5];
   logic [4:0]  junk_cause;
   int          env_ix;

   always_comb begin
      env_ix          = csr_idx(csr_uop_o.csr_addr);
      csr_exception_i = (env_ix < 0);
      csr_result_i    = 32'h0;
      csr_ecause_i    = junk_cause;
      if (env_ix < 0) csr_ecause_i = 5'd2;
      else            csr_result_i = env_csr[env_ix];
   end

   always @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < 5; k++) env_csr[k] <= 32'h0;
      end else if (csr_valid_o && !csr_exception_i) begin
         env_csr[env_ix] <= csr_new(csr_uop_o, csr_rs1_data_o, env_csr[env_ix]);
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // One transaction accepted at cycle 0. hd/ld: cycles of wrong head / busy LSU after accept;
   // wd: cycles wb_ready_i stays low once writeback is offered; fl: cycle of a one-cycle flush.
   task automatic run_txn(input string nm, input csr_op_e op, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] imm, input logic [5:0] tag,
                          input int hd, input int ld, input int wd, input int fl,
                          input logic [31:0] exp_res, input logic exp_exc);
      uop_t        u;
      uop_t        junk;
      logic [31:0] rnd;
      int          exec_c, hs_c, end_busy, end_c, ix;
      bit          killed_pre, killed_wb, fence_exp;
      int          n_exec = 0, first_exec = -1, n_wb = 0, n_fence = 0, fence_c = -1, rdy_bad = 0;
      bit          exec_pay_ok = 1'b0, stable_bad = 1'b0;
      logic [5:0]  cap_tag = '0;
      logic [31:0] cap_res = '0;
      logic        cap_exc = 1'b0;
      logic [4:0]  cap_cause = '0;
      u          = '{is_csr: 1'b1, csr_op: op, csr_addr: addr, imm: imm};
      exec_c     = ((hd > ld) ? hd : ld) + 2;
      hs_c       = exec_c + 1 + wd;
      killed_pre = (fl >= 1) && (fl <= exec_c);
      killed_wb  = (fl > exec_c) && (fl <= hs_c);
      end_busy   = (killed_pre || killed_wb) ? fl : hs_c;
      end_c      = end_busy + 3;
      fence_exp  = !killed_pre && !killed_wb && !exp_exc &&
                   (addr == 12'h180 || addr == 12'h300);
      ix         = csr_idx(addr);
      if (!killed_pre && !exp_exc && ix >= 0) ref_csr[ix] = csr_new(u, rs1, ref_csr[ix]);
      for (int c = 0; c <= end_c; c++) begin
         rnd              = $urandom;
         junk             = uop_t'(rnd[20:0]);
         req_valid_i      = (c <= end_busy);
         req_uop_i        = (c == 0) ? u : junk;
         req_rs1_data_i   = (c == 0) ? rs1 : $urandom;
         req_rob_tag_i    = (c == 0) ? tag : rnd[26:21];
         rob_head_valid_i = 1'b1;
         rob_head_tag_i   = tag;
         if (c >= 1 && c <= hd) begin
            if (rnd[27]) rob_head_valid_i = 1'b0;
            else         rob_head_tag_i = tag ^ 6'(6'd1 << $urandom_range(0, 5));
         end
         lsu_idle_i = !(c >= 1 && c <= ld);
         flush_i    = (c == fl);
         wb_ready_i = (c <= exec_c) ? rnd[28] : (c >= hs_c);
         junk_cause = {rnd[31:29], rnd[0], 1'b1};
         #3;
         if (c == 0) chk({nm, ".ready_idle"}, 64'(req_ready_o), 64'd1);
         if (csr_valid_o) begin
            n_exec++;
            if (first_exec < 0) begin
               first_exec  = c;
               exec_pay_ok = (csr_uop_o == u) && (csr_rs1_data_o == rs1) && (csr_rob_tag_o == tag);
            end
         end
         if (wb_valid_o) begin
            if (n_wb == 0) begin
               cap_tag = wb_rob_tag_o; cap_res = wb_result_o;
               cap_exc = wb_exception_o; cap_cause = wb_ecause_o;
            end else if (wb_rob_tag_o !== cap_tag || wb_result_o !== cap_res ||
                         wb_exception_o !== cap_exc || wb_ecause_o !== cap_cause) begin
               stable_bad = 1'b1;
            end
            n_wb++;
         end
         if (fence_o) begin
            n_fence++;
            fence_c = c;
         end
         if (c >= 1 && c <= end_busy && req_ready_o) rdy_bad++;
         if (c == end_c) begin
            chk({nm, ".busy_end"}, 64'(busy_o), 64'd0);
            chk({nm, ".ready_end"}, 64'(req_ready_o), 64'd1);
         end
         step();
      end
      chk({nm, ".exec_cnt"}, 64'(n_exec), killed_pre ? 64'd0 : 64'd1);
      if (!killed_pre) begin
         chk({nm, ".exec_cycle"}, 64'(first_exec), 64'(exec_c));
         chk({nm, ".exec_payload"}, 64'(exec_pay_ok), 64'd1);
      end
      chk({nm, ".wb_cycles"}, 64'(n_wb),
          killed_pre ? 64'd0 : (killed_wb ? 64'(fl - exec_c) : 64'(wd + 1)));
      if (!killed_pre) begin
         chk({nm, ".wb_tag"}, 64'(cap_tag), 64'(tag));
         chk({nm, ".wb_result"}, 64'(cap_res), 64'(exp_res));
         chk({nm, ".wb_exc"}, 64'(cap_exc), 64'(exp_exc));
         chk({nm, ".wb_cause"}, 64'(cap_cause), exp_exc ? 64'd2 : 64'd0);
      end
      chk({nm, ".wb_stable"}, 64'(stable_bad), 64'd0);
      chk({nm, ".fence_cnt"}, 64'(n_fence), fence_exp ? 64'd1 : 64'd0);
      if (fence_exp) chk({nm, ".fence_cycle"}, 64'(fence_c), 64'(hs_c + 1));
      chk({nm, ".ready_busy"}, 64'(rdy_bad), 64'd0);
      if (ix >= 0) chk({nm, ".csr_state"}, 64'(env_csr[ix]), 64'(ref_csr[ix]));
   endtask

   typedef struct {
      csr_op_e     op;
      logic [11:0] addr;
      logic [31:0] rs1;
      logic [4:0]  imm;
      logic [5:0]  tag;
      int          hd, ld, wd;
      logic [31:0] exp_res;
      logic        exp_exc;
   } vec_t;

   vec_t        tbl [11];
   csr_op_e     ops [6];
   logic [11:0] addrs [6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n_cv;
      int          hd, ld, wd, fl, ix;
      csr_op_e     op;
      logic [11:0] addr;
      logic [31:0] res;
      tbl[0]  = '{CSR_RW,  12'h305, 32'h8000_0000, 5'd0,  6'd5,  0, 0, 0, 32'h0,         1'b0};
      tbl[1]  = '{CSR_RS,  12'h180, 32'h0,         5'd0,  6'd12, 2, 0, 4, 32'h0,         1'b0};
      tbl[2]  = '{CSR_RW,  12'h7C0, 32'hFFFF_FFFF, 5'd0,  6'd33, 0, 3, 1, 32'h0,         1'b1};
      tbl[3]  = '{CSR_RS,  12'h305, 32'h1,         5'd0,  6'd63, 1, 1, 0, 32'h8000_0000, 1'b0};
      tbl[4]  = '{CSR_RC,  12'h305, 32'h8000_0000, 5'd0,  6'd0,  0, 0, 2, 32'h8000_0001, 1'b0};
      tbl[5]  = '{CSR_RWI, 12'h300, 32'hAAAA_AAAA, 5'd5,  6'd20, 3, 1, 0, 32'h0,         1'b0};
      tbl[6]  = '{CSR_RSI, 12'h300, 32'h5555_5555, 5'd0,  6'd21, 0, 2, 1, 32'h5,         1'b0};
      tbl[7]  = '{CSR_RW,  12'h340, 32'hDEAD_BEEF, 5'd0,  6'd41, 0, 0, 0, 32'h0,         1'b0};
      tbl[8]  = '{CSR_RCI, 12'h340, 32'h0,         5'd15, 6'd2,  1, 0, 3, 32'hDEAD_BEEF, 1'b0};
      tbl[9]  = '{CSR_RS,  12'h340, 32'h0,         5'd0,  6'd3,  0, 0, 0, 32'hDEAD_BEE0, 1'b0};
      tbl[10] = '{CSR_RW,  12'h180, 32'h8000_0042, 5'd0,  6'd44, 2, 2, 1, 32'h0,         1'b0};
      ops   = '{CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI};
      addrs = '{12'h180, 12'h300, 12'h305, 12'h340, 12'h341, 12'h7C0};
      for (int k = 0; k < 5; k++) ref_csr[k] = 32'h0;

      rst_i = 1'b1; req_valid_i = 1'b0; req_uop_i = '0; req_rs1_data_i = '0;
      req_rob_tag_i = '0; rob_head_valid_i = 1'b0; rob_head_tag_i = '0; lsu_idle_i = 1'b1;
      flush_i = 1'b0; wb_ready_i = 1'b0; junk_cause = 5'd0;
      repeat (2) step();
      #3;
      chk("rst.ready", 64'(req_ready_o), 64'd0);
      chk("rst.busy", 64'(busy_o), 64'd0);
      chk("rst.wb_valid", 64'(wb_valid_o), 64'd0);
      chk("rst.fence", 64'(fence_o), 64'd0);
      step();
      rst_i = 1'b0;
      step();

      // Reset asserted while waiting with the issue condition already met.
      req_valid_i = 1'b1; req_uop_i = '{1'b1, CSR_RW, 12'h305, 5'd0}; req_rs1_data_i = 32'h55;
      req_rob_tag_i = 6'd9; rob_head_valid_i = 1'b1; rob_head_tag_i = 6'd9; lsu_idle_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      #3;
      chk("t1.busy_wait", 64'(busy_o), 64'd1);
      rst_i = 1'b1;
      #1;
      chk("t1.busy", 64'(busy_o), 64'd0);
      chk("t1.csr_valid", 64'(csr_valid_o), 64'd0);
      chk("t1.wb_valid", 64'(wb_valid_o), 64'd0);
      chk("t1.ready", 64'(req_ready_o), 64'd0);
      chk("t1.held_tag", 64'(csr_rob_tag_o), 64'd0);
      step();
      step();
      rst_i = 1'b0;
      n_cv = 0;
      for (int c = 0; c < 4; c++) begin
         #3;
         if (csr_valid_o || busy_o) n_cv++;
         step();
      end
      chk("t1.idle_after", 64'(n_cv), 64'd0);

      for (int i = 0; i < 11; i++)
         run_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].rs1, tbl[i].imm,
                 tbl[i].tag, tbl[i].hd, tbl[i].ld, tbl[i].wd, -1, tbl[i].exp_res, tbl[i].exp_exc);

      // mtvec is 1 and satp is 0x8000_0042 at this point.
      run_txn("t3", CSR_RS, 12'h305, 32'h0, 5'd0, 6'd7, 10, 13, 0, -1, 32'h1, 1'b0);
      run_txn("t6", CSR_RW, 12'h305, 32'h1234, 5'd0, 6'd8, 0, 0, 0, 2, 32'h1, 1'b0);
      run_txn("flush_wait", CSR_RW, 12'h305, 32'h99, 5'd0, 6'd9, 3, 0, 0, 2, 32'h1, 1'b0);
      run_txn("flush_wb", CSR_RW, 12'h180, 32'h7, 5'd0, 6'd10, 0, 0, 3, 4, 32'h8000_0042, 1'b0);
      run_txn("after_wb", CSR_RS, 12'h180, 32'h0, 5'd0, 6'd11, 0, 0, 0, -1, 32'h7, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op   = ops[$urandom_range(0, 5)];
         addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 5)];
         hd   = $urandom_range(0, 4);
         ld   = $urandom_range(0, 4);
         wd   = $urandom_range(0, 3);
         fl   = -1;
         if ($urandom_range(0, 3) == 0) fl = $urandom_range(1, ((hd > ld) ? hd : ld) + 4 + wd);
         ix   = csr_idx(addr);
         res  = (ix < 0) ? 32'h0 : ref_csr[ix];
         run_txn($sformatf("rnd%0d", i), op, addr, $urandom, 5'($urandom), 6'($urandom),
                 hd, ld, wd, fl, res, ix < 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
